// File: rtl/cam_pkg.sv
// cam_pkg: shared constants, word type, operation codes and FSM states for the CAM controller.
package cam_pkg;
    localparam int CAM_ENTRIES = 32;
    localparam int CAM_WIDTH   = 32;
    localparam int CAM_IDX_W   = 5;
    typedef logic [CAM_WIDTH-1:0] cam_word_t;
    typedef enum logic [1:0] {SEARCH, WRITE, INVALIDATE, READ} cam_op_e;
    typedef enum logic [1:0] {IDLE, COMPARE, ENCODE, RESP} cam_state_e;
endpackage

// File: rtl/cam_priority_encoder.sv
// cam_priority_encoder: lowest-set-bit index of a match vector, plus any-hit flag.
module cam_priority_encoder #(
    parameter int N     = 32,
    parameter int IDX_W = 5
) (
    input  logic [N-1:0]     match,
    output logic [IDX_W-1:0] index,
    output logic             any_hit
);
    always_comb begin
        index = '0;
        for (int i = N - 1; i >= 0; i--) index = match[i] ? IDX_W'(i) : index;
        any_hit = |match;
    end
endmodule

// File: rtl/cam_array_ctrl.sv
// cam_array_ctrl: CAM entry storage, valid bits and one-request-at-a-time search/write/invalidate/read control.
module cam_array_ctrl
    import cam_pkg::*;
#(
    parameter int ENTRIES = CAM_ENTRIES,
    parameter int WIDTH   = CAM_WIDTH,
    parameter int IDX_W   = CAM_IDX_W
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic [1:0]                      req_op_i,
    input  logic [IDX_W-1:0]                req_index_i,
    input  logic [WIDTH-1:0]                req_data_i,
    output logic                            resp_valid_o,
    input  logic                            resp_ready_i,
    output logic                            resp_hit_o,
    output logic [IDX_W-1:0]                resp_index_o,
    output logic [WIDTH-1:0]                resp_data_o,
    output logic [ENTRIES-1:0][WIDTH-1:0]   mem_o,
    output logic [IDX_W-1:0]                sel_o,
    input  logic [WIDTH-1:0]                rdata_i,
    output logic [ENTRIES-1:0]              valid_o
);
    cam_state_e          state_q, state_d;
    cam_op_e             op_q;
    logic [IDX_W-1:0]    idx_q;
    logic [WIDTH-1:0]    data_q;
    logic [ENTRIES-1:0]  match_q, hits;
    logic                old_valid_q;
    logic [IDX_W-1:0]    enc_index, index_d;
    logic                enc_hit, hit_d;

    cam_priority_encoder #(.N(ENTRIES), .IDX_W(IDX_W)) u_enc (
        .match   (match_q),
        .index   (enc_index),
        .any_hit (enc_hit)
    );

    assign req_ready_o = state_q == IDLE;
    assign resp_data_o = rdata_i;

    always_comb begin
        hits = '0;
        for (int i = 0; i < ENTRIES; i++) hits[i] = valid_o[i] && mem_o[i] == data_q;
    end

    always_comb begin
        state_d = state_q == IDLE    ? (req_valid_i ? COMPARE : IDLE) :
                  state_q == COMPARE ? ENCODE :
                  state_q == ENCODE  ? RESP :
                  (resp_ready_i ? IDLE : RESP);
        hit_d   = op_q == SEARCH     ? enc_hit :
                  op_q == WRITE      ? 1'b1 :
                  op_q == INVALIDATE ? old_valid_q : valid_o[idx_q];
        index_d = op_q == SEARCH ? enc_index : idx_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q         <= SEARCH;
            idx_q        <= '0;
            data_q       <= '0;
            match_q      <= '0;
            old_valid_q  <= 1'b0;
            mem_o        <= '0;
            valid_o      <= '0;
            resp_valid_o <= 1'b0;
            resp_hit_o   <= 1'b0;
            resp_index_o <= '0;
            sel_o        <= '0;
        end else begin
            if (state_q == IDLE && req_valid_i) begin
                op_q   <= cam_op_e'(req_op_i);
                idx_q  <= req_index_i;
                data_q <= req_data_i;
            end
            if (state_q == COMPARE) begin
                if (op_q == SEARCH) match_q <= hits;
                if (op_q == WRITE) begin
                    mem_o[idx_q]   <= data_q;
                    valid_o[idx_q] <= 1'b1;
                end
                if (op_q == INVALIDATE) begin
                    old_valid_q    <= valid_o[idx_q];
                    valid_o[idx_q] <= 1'b0;
                end
            end
            // sel_o tracks the response index so the mux output is the addressed entry during RESP
            if (state_q == ENCODE) begin
                resp_hit_o   <= hit_d;
                resp_index_o <= index_d;
                sel_o        <= index_d;
                resp_valid_o <= 1'b1;
            end
            if (state_q == RESP && resp_ready_i) resp_valid_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cam_array_ctrl.sv
// tb_cam_array_ctrl: directed scenario tests for cam_array_ctrl with a behavioural read mux.
module tb_cam_array_ctrl;
    logic clk = 0, rst_n = 0;
    logic req_valid = 0, req_ready, resp_valid, resp_ready = 1, resp_hit;
    logic [1:0] req_op = 0;
    logic [4:0] req_index = 0, resp_index, sel;
    logic [31:0] req_data = 0, resp_data, rdata, valid;
    logic [31:0][31:0] mem;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;
    assign rdata = mem[sel];

    cam_array_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_index_i(req_index), .req_data_i(req_data),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_hit_o(resp_hit),
        .resp_index_o(resp_index), .resp_data_o(resp_data), .mem_o(mem), .sel_o(sel),
        .rdata_i(rdata), .valid_o(valid)
    );

    task automatic do_op(input logic [1:0] op, input logic [4:0] idx, input logic [31:0] d,
                         input logic rr, output logic hit, output logic [4:0] ri,
                         output logic [31:0] rd, output int lat, output logic busy);
        @(negedge clk);
        resp_ready = rr; req_valid = 1; req_op = op; req_index = idx; req_data = d;
        @(negedge clk);
        req_valid = 0; lat = 0; busy = 0;
        while (!resp_valid && lat < 20) begin
            busy |= req_ready;
            @(negedge clk);
            lat++;
        end
        busy |= req_ready;
        hit = resp_hit; ri = resp_index; rd = resp_data;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 0;
        repeat (2) @(negedge clk);
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %0b exp 1", req_ready); end
        tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_resp_valid got %0b exp 0", resp_valid); end
        tests++; if (resp_hit !== 1'b0) begin fails++; $display("FAIL reset_resp_hit got %0b exp 0", resp_hit); end
        tests++; if (resp_index !== 5'd0) begin fails++; $display("FAIL reset_resp_index got %0d exp 0", resp_index); end
        tests++; if (sel !== 5'd0) begin fails++; $display("FAIL reset_sel got %0d exp 0", sel); end
        tests++; if (valid !== 32'h0) begin fails++; $display("FAIL reset_valid got %h exp 0", valid); end
        tests++; if (mem !== '0) begin fails++; $display("FAIL reset_mem got nonzero exp 0"); end
        rst_n = 1;
    endtask

    task automatic test_read_after_reset;
        logic hit, busy; logic [4:0] ri; logic [31:0] rd; int lat;
        do_op(2'd3, 5'd7, 32'h0, 1'b1, hit, ri, rd, lat, busy);
        tests++; if (lat !== 2) begin fails++; $display("FAIL read7_latency got %0d exp 2", lat); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL read7_ready_low got %0b exp 0", busy); end
        tests++; if (hit !== 1'b0) begin fails++; $display("FAIL read7_hit got %0b exp 0", hit); end
        tests++; if (ri !== 5'd7) begin fails++; $display("FAIL read7_index got %0d exp 7", ri); end
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL read7_data got %h exp 00000000", rd); end
        tests++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin fails++; $display("FAIL read7_back_idle got ready=%0b valid=%0b exp 1/0", req_ready, resp_valid); end
    endtask

    task automatic test_zero_search;
        logic hit, busy; logic [4:0] ri; logic [31:0] rd; int lat;
        do_op(2'd0, 5'd17, 32'h0, 1'b1, hit, ri, rd, lat, busy);
        tests++; if (hit !== 1'b0) begin fails++; $display("FAIL zsearch_hit got %0b exp 0", hit); end
        tests++; if (ri !== 5'd0) begin fails++; $display("FAIL zsearch_index got %0d exp 0", ri); end
        tests++; if (lat !== 2) begin fails++; $display("FAIL zsearch_latency got %0d exp 2", lat); end
    endtask

    task automatic test_write_search;
        logic hit, busy; logic [4:0] ri; logic [31:0] rd; int lat;
        do_op(2'd1, 5'd3, 32'hDEADBEEF, 1'b1, hit, ri, rd, lat, busy);
        tests++; if (hit !== 1'b1 || ri !== 5'd3) begin fails++; $display("FAIL write3_resp got hit=%0b idx=%0d exp 1/3", hit, ri); end
        tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL write3_echo got %h exp deadbeef", rd); end
        do_op(2'd0, 5'd0, 32'hDEADBEEF, 1'b1, hit, ri, rd, lat, busy);
        tests++; if (hit !== 1'b1) begin fails++; $display("FAIL search_db_hit got %0b exp 1", hit); end
        tests++; if (ri !== 5'd3) begin fails++; $display("FAIL search_db_index got %0d exp 3", ri); end
        tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL search_db_data got %h exp deadbeef", rd); end
    endtask

    task automatic test_duplicates;
        logic hit, busy; logic [4:0] ri; logic [31:0] rd; int lat;
        do_op(2'd1, 5'd9, 32'hA5A5A5A5, 1'b1, hit, ri, rd, lat, busy);
        do_op(2'd1, 5'd4, 32'hA5A5A5A5, 1'b1, hit, ri, rd, lat, busy);
        do_op(2'd0, 5'd0, 32'hA5A5A5A5, 1'b1, hit, ri, rd, lat, busy);
        tests++; if (hit !== 1'b1 || ri !== 5'd4) begin fails++; $display("FAIL dup_search_lowest got hit=%0b idx=%0d exp 1/4", hit, ri); end
        do_op(2'd2, 5'd4, 32'h0, 1'b1, hit, ri, rd, lat, busy);
        tests++; if (hit !== 1'b1 || ri !== 5'd4) begin fails++; $display("FAIL inval4_resp got hit=%0b idx=%0d exp 1/4", hit, ri); end
        do_op(2'd0, 5'd0, 32'hA5A5A5A5, 1'b1, hit, ri, rd, lat, busy);
        tests++; if (hit !== 1'b1 || ri !== 5'd9) begin fails++; $display("FAIL dup_search_after_inval got hit=%0b idx=%0d exp 1/9", hit, ri); end
        tests++; if (rd !== 32'hA5A5A5A5) begin fails++; $display("FAIL dup_search_data got %h exp a5a5a5a5", rd); end
        do_op(2'd2, 5'd4, 32'h0, 1'b1, hit, ri, rd, lat, busy);
        tests++; if (hit !== 1'b0) begin fails++; $display("FAIL inval4_again_hit got %0b exp 0", hit); end
        tests++; if (valid !== 32'h0000_0208) begin fails++; $display("FAIL dup_valid got %h exp 00000208", valid); end
        tests++; if (mem[4] !== 32'hA5A5A5A5) begin fails++; $display("FAIL inval_keeps_mem got %h exp a5a5a5a5", mem[4]); end
    endtask

    task automatic test_resp_hold;
        logic hit, busy; logic [4:0] ri; logic [31:0] rd; int lat;
        do_op(2'd3, 5'd9, 32'h0, 1'b0, hit, ri, rd, lat, busy);
        tests++; if (hit !== 1'b1 || ri !== 5'd9) begin fails++; $display("FAIL hold_read9 got hit=%0b idx=%0d exp 1/9", hit, ri); end
        for (int c = 0; c < 10; c++) begin
            req_valid = (c == 4); req_op = 2'd1; req_index = 5'd0; req_data = 32'h1;
            @(negedge clk);
            tests++; if (resp_valid !== 1'b1) begin fails++; $display("FAIL hold_valid c=%0d got %0b exp 1", c, resp_valid); end
            tests++; if (resp_index !== 5'd9) begin fails++; $display("FAIL hold_index c=%0d got %0d exp 9", c, resp_index); end
            tests++; if (resp_data !== 32'hA5A5A5A5) begin fails++; $display("FAIL hold_data c=%0d got %h exp a5a5a5a5", c, resp_data); end
            tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL hold_ready c=%0d got %0b exp 0", c, req_ready); end
        end
        req_valid = 0; resp_ready = 1;
        @(negedge clk);
        tests++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL hold_release got valid=%0b ready=%0b exp 0/1", resp_valid, req_ready); end
        tests++; if (valid !== 32'h0000_0208) begin fails++; $display("FAIL hold_pulse_ignored got %h exp 00000208", valid); end
    endtask

    task automatic test_reset_abort;
        logic hit, busy; logic [4:0] ri; logic [31:0] rd; int lat;
        @(negedge clk);
        resp_ready = 1; req_valid = 1; req_op = 2'd1; req_index = 5'd5; req_data = 32'h12345678;
        @(negedge clk);
        req_valid = 0; rst_n = 0;
        #1;
        tests++; if (valid !== 32'h0) begin fails++; $display("FAIL abort_async_valid got %h exp 0", valid); end
        @(negedge clk);
        rst_n = 1;
        repeat (3) begin
            @(negedge clk);
            tests++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL abort_no_resp got valid=%0b ready=%0b exp 0/1", resp_valid, req_ready); end
        end
        do_op(2'd3, 5'd5, 32'h0, 1'b1, hit, ri, rd, lat, busy);
        tests++; if (hit !== 1'b0 || ri !== 5'd5) begin fails++; $display("FAIL abort_read5 got hit=%0b idx=%0d exp 0/5", hit, ri); end
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL abort_read5_data got %h exp 00000000", rd); end
    endtask

    initial begin
        test_reset();
        test_read_after_reset();
        test_zero_search();
        test_write_search();
        test_duplicates();
        test_resp_hold();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
